pixel_plot_arbiter: RTL and testbench

Shares the single VGA adapter pixel-write port among several drawing engines: start-screen painter, screen resetter, note-block drawer and scanner. Each engine issues pixel beats (x, y, colour) grouped into bursts. The arbiter grants one engine at a time, round-robin, and holds the grant for a whole burst. It drives the registered VGA_X/VGA_Y/VGA_COLOR/plot outputs, replacing ad-hoc state-based muxing at the top level.

---
 rtl/pianissimo_vga_pkg.sv | 27 ++
 rtl/rr_priority_picker.sv | 35 +++
 rtl/pixel_plot_arbiter.sv | 174 +++++++++++++++++
 tb/tb_pixel_plot_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pianissimo_vga_pkg.sv
// Shared definitions for the VGA pixel-write path: screen geometry, arbiter
// state encoding, requester indices and a small wrap-around helper.
package pianissimo_vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  // Width of grant_id / rr_ptr; covers up to 8 requesters.
  localparam int GRANT_W = 3;

  localparam int REQ_STARTSCREEN = 0;
  localparam int REQ_RESETSCREEN = 1;
  localparam int REQ_MAINSTATE   = 2;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // (idx + 1) mod n, for idx already in 0..n-1.
  function automatic logic [GRANT_W-1:0] wrap_inc(input logic [GRANT_W-1:0] idx,
                                                  input int n);
    if (int'(idx) >= n - 1) return '0;
    else                    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: returns the first asserted valid bit found
// scanning upward from ptr_i, wrapping modulo NUM_REQ.
//   valid_i  per-requester valid
//   ptr_i    scan start index (0..NUM_REQ-1)
//   idx_o    index of the selected requester (0 when none found)
//   found_o  high when any valid bit is set
module rr_priority_picker
  import pianissimo_vga_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [GRANT_W-1:0] ptr_i,
  output logic [GRANT_W-1:0] idx_o,
  output logic               found_o
);

  // Offsets are walked from the farthest to the nearest, so the last hit
  // written (smallest offset from ptr_i) is the one that wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (valid_i[j] &&
            (j == ((int'(ptr_i) + i >= NUM_REQ) ? int'(ptr_i) + i - NUM_REQ
                                                : int'(ptr_i) + i))) begin
          idx_o   = GRANT_W'(j);
          found_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pixel_plot_arbiter.sv
// Round-robin arbiter sharing the VGA adapter pixel-write port between the
// drawing engines. One engine is granted per burst; its beats are registered
// onto VGA_X/VGA_Y/VGA_COLOR/plot with one cycle of latency.
//   CLOCK_50, resetn        clock, async active-low reset
//   req_valid/req_last      per-engine beat valid and end-of-burst flag
//   req_x/req_y/req_color   packed per-engine beat data (engine i at [i*W +: W])
//   req_ready               per-engine accept, at most one bit high
//   VGA_X/VGA_Y/VGA_COLOR   registered pixel; hold value when plot=0
//   plot                    registered write enable (0 for clipped beats)
//   grant_id, busy          current grantee, high while a grant is held
//   dbg_state, dbg_rr_ptr   FSM state and round-robin pointer for observation
//
// Handshake: a beat transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high. ready depends only on registered state, never
// on valid, and stays high for the whole grant (no backpressure). Engines
// without ready must hold valid and data stable until they are granted.
module pixel_plot_arbiter
  import pianissimo_vga_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 24,
  parameter int TIMEOUT = 255
) (
  input  logic                       CLOCK_50,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*X_W-1:0]     req_x,
  input  logic [NUM_REQ*Y_W-1:0]     req_y,
  input  logic [NUM_REQ*COLOR_W-1:0] req_color,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [X_W-1:0]             VGA_X,
  output logic [Y_W-1:0]             VGA_Y,
  output logic [COLOR_W-1:0]         VGA_COLOR,
  output logic                       plot,
  output logic [GRANT_W-1:0]         grant_id,
  output logic                       busy,
  output arb_state_e                 dbg_state,
  output logic [GRANT_W-1:0]         dbg_rr_ptr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;

  logic [X_W-1:0]     vga_x_q;
  logic [Y_W-1:0]     vga_y_q;
  logic [COLOR_W-1:0] vga_c_q;
  logic               plot_q;

  logic               g_valid, g_last;
  logic [X_W-1:0]     g_x;
  logic [Y_W-1:0]     g_y;
  logic [COLOR_W-1:0] g_c;
  logic               accept, in_screen;
  logic [GRANT_W-1:0] pick_idx;
  logic               pick_found;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Select the grantee's beat.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_x     = '0;
    g_y     = '0;
    g_c     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GRANT_W'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_x     = req_x[i*X_W +: X_W];
        g_y     = req_y[i*Y_W +: Y_W];
        g_c     = req_color[i*COLOR_W +: COLOR_W];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == ARB_LOCKED) && (grant_q == GRANT_W'(i));
    end
  end

  assign accept    = (state_q == ARB_LOCKED) && g_valid;
  assign in_screen = (int'(g_x) < SCREEN_W) && (int'(g_y) < SCREEN_H);
  assign cnt_inc   = cnt_q + 1'b1;

  // Release happens on the idle cycle whose incremented count reaches
  // TIMEOUT, so the grant survives exactly TIMEOUT idle cycles.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (g_valid) begin
          cnt_d = '0;
          if (g_last) begin
            state_d = ARB_IDLE;
            ptr_d   = wrap_inc(grant_q, NUM_REQ);
          end
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          cnt_d   = '0;
          state_d = ARB_IDLE;
          ptr_d   = wrap_inc(grant_q, NUM_REQ);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clipped beats are consumed but leave the pixel registers untouched.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      vga_x_q <= '0;
      vga_y_q <= '0;
      vga_c_q <= '0;
      plot_q  <= 1'b0;
    end else begin
      plot_q <= accept && in_screen;
      if (accept && in_screen) begin
        vga_x_q <= g_x;
        vga_y_q <= g_y;
        vga_c_q <= g_c;
      end
    end
  end

  assign VGA_X      = vga_x_q;
  assign VGA_Y      = vga_y_q;
  assign VGA_COLOR  = vga_c_q;
  assign plot       = plot_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q == ARB_LOCKED);
  assign dbg_state  = state_q;
  assign dbg_rr_ptr = ptr_q;

endmodule

// File: tb/tb_pixel_plot_arbiter.sv
module tb_pixel_plot_arbiter;
  import pianissimo_vga_pkg::*;

  localparam int NR = 3;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 24;
  localparam int PW = XW + YW + CW;

  // ---------------- clock / reset ----------------
  logic clk;
  logic resetn;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          v_a [NR];
  logic          l_a [NR];
  logic [XW-1:0] x_a [NR];
  logic [YW-1:0] y_a [NR];
  logic [CW-1:0] c_a [NR];

  wire  [NR-1:0]    req_valid;
  wire  [NR-1:0]    req_last;
  wire  [NR*XW-1:0] req_x;
  wire  [NR*YW-1:0] req_y;
  wire  [NR*CW-1:0] req_color;
  logic [NR-1:0]    req_ready;
  logic [XW-1:0]    VGA_X;
  logic [YW-1:0]    VGA_Y;
  logic [CW-1:0]    VGA_COLOR;
  logic             plot;
  logic [2:0]       grant_id;
  logic             busy;
  arb_state_e       dbg_state;
  logic [2:0]       dbg_rr_ptr;

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign req_valid[g]            = v_a[g];
    assign req_last[g]             = l_a[g];
    assign req_x[g*XW +: XW]       = x_a[g];
    assign req_y[g*YW +: YW]       = y_a[g];
    assign req_color[g*CW +: CW]   = c_a[g];
  end

  pixel_plot_arbiter #(
    .NUM_REQ(NR), .X_W(XW), .Y_W(YW), .COLOR_W(CW), .TIMEOUT(4)
  ) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_color  (req_color),
    .req_ready  (req_ready),
    .VGA_X      (VGA_X),
    .VGA_Y      (VGA_Y),
    .VGA_COLOR  (VGA_COLOR),
    .plot       (plot),
    .grant_id   (grant_id),
    .busy       (busy),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [2:0]    exp_grant_q[$];
  int            n_checks;
  int            n_pass;
  bit            mon_en;
  bit            gap_chk;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Pops an expected pixel whenever plot is presented.
  task automatic plot_mon();
    logic [PW-1:0] e;
    int            ec;
    forever begin
      @(negedge clk);
      if (mon_en && plot) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "plot_unexpected", {VGA_X, VGA_Y, VGA_COLOR}, 0);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check({VGA_X, VGA_Y, VGA_COLOR} === e, "plot_pixel", {VGA_X, VGA_Y, VGA_COLOR}, e);
          check(cyc == ec, "plot_latency", cyc, ec);
        end
      end
    end
  endtask

  // Checks grant order on every rising edge of busy, and the single
  // arbitration bubble between back-to-back bursts when enabled.
  task automatic grant_mon();
    logic       prev_busy;
    int         fall_cyc;
    logic [2:0] g;
    prev_busy = 1'b0;
    fall_cyc  = -1;
    forever begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        if (exp_grant_q.size() == 0) begin
          check(1'b0, "grant_unexpected", grant_id, 0);
        end else begin
          g = exp_grant_q.pop_front();
          check(grant_id === g, "grant_order", grant_id, g);
        end
        if (gap_chk && fall_cyc >= 0) check(cyc - fall_cyc == 1, "grant_bubble", cyc - fall_cyc, 1);
      end
      if (!busy && prev_busy) fall_cyc = cyc;
      prev_busy = busy;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Streams n beats (x0+k, y0, c0+k) from engine e. Called at posedge+1,
  // returns at posedge+1 after the final acceptance edge.
  task automatic send_burst(input int e, input int n, input logic [XW-1:0] x0,
                            input logic [YW-1:0] y0, input logic [CW-1:0] c0,
                            input bit with_last);
    int k;
    int wait_cyc;
    int last_acc;
    k        = 0;
    wait_cyc = 0;
    last_acc = -1;
    while (k < n) begin
      v_a[e] = 1'b1;
      l_a[e] = with_last && (k == n - 1);
      x_a[e] = x0 + XW'(k);
      y_a[e] = y0;
      c_a[e] = c0 + CW'(k);
      @(negedge clk);
      if (req_ready[e]) begin
        if (last_acc >= 0) check(cyc == last_acc + 1, "no_backpressure", cyc, last_acc + 1);
        last_acc = cyc;
        if (int'(x_a[e]) < 160 && int'(y_a[e]) < 120) begin
          exp_q.push_back({x_a[e], y_a[e], c_a[e]});
          exp_cyc_q.push_back(cyc + 1);
        end
        k++;
      end else begin
        wait_cyc++;
        if (wait_cyc > 200) begin
          check(1'b0, "ready_timeout", e, 0);
          break;
        end
      end
      @(posedge clk);
      #1;
    end
    v_a[e] = 1'b0;
    l_a[e] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    n_checks = 0;
    n_pass   = 0;
    mon_en   = 1'b1;
    gap_chk  = 1'b0;
    resetn   = 1'b0;
    for (int i = 0; i < NR; i++) begin
      v_a[i] = 1'b0; l_a[i] = 1'b0; x_a[i] = '0; y_a[i] = '0; c_a[i] = '0;
    end
    fork
      plot_mon();
      grant_mon();
    join_none

    // Reset state
    @(negedge clk);
    check({VGA_X, VGA_Y, VGA_COLOR, plot} === '0, "rst_pixel", {VGA_X, VGA_Y, VGA_COLOR, plot}, 0);
    check({req_ready, busy, grant_id, dbg_rr_ptr} === '0, "rst_ctrl",
          {req_ready, busy, grant_id, dbg_rr_ptr}, 0);
    @(negedge clk);
    resetn = 1'b1;
    idle(2);

    // Three-way contention: 0,1,2,0 with one bubble between bursts
    exp_grant_q.push_back(3'd0); exp_grant_q.push_back(3'd1);
    exp_grant_q.push_back(3'd2); exp_grant_q.push_back(3'd0);
    gap_chk = 1'b1;
    fork
      begin
        send_burst(0, 4, 8'd10, 7'd1, 24'h100000, 1'b1);
        send_burst(0, 4, 8'd40, 7'd4, 24'h400000, 1'b1);
      end
      send_burst(1, 4, 8'd20, 7'd2, 24'h200000, 1'b1);
      send_burst(2, 4, 8'd30, 7'd3, 24'h300000, 1'b1);
    join
    gap_chk = 1'b0;
    idle(3);

    // Data path: single corner beat from engine 2
    exp_grant_q.push_back(3'd2);
    send_burst(2, 1, 8'd159, 7'd119, 24'hFF8000, 1'b1);
    @(negedge clk);
    check({VGA_X, VGA_Y, VGA_COLOR, plot} === {8'd159, 7'd119, 24'hFF8000, 1'b1}, "dp_vga",
          {VGA_X, VGA_Y, VGA_COLOR, plot}, {8'd159, 7'd119, 24'hFF8000, 1'b1});
    check(req_ready[2] === 1'b0, "dp_ready_drop", req_ready[2], 0);
    idle(3);

    // Clipping: x=160 is consumed but not plotted
    exp_grant_q.push_back(3'd0);
    send_burst(0, 1, 8'd160, 7'd5, 24'h123456, 1'b1);
    @(negedge clk);
    check(plot === 1'b0, "clip_plot", plot, 0);
    check({VGA_X, VGA_Y} === {8'd159, 7'd119}, "clip_hold", {VGA_X, VGA_Y}, {8'd159, 7'd119});
    idle(3);

    // Timeout: move pointer to 0, engine 0 stalls after 2 beats, engine 1 waits
    exp_grant_q.push_back(3'd2);
    exp_grant_q.push_back(3'd0);
    exp_grant_q.push_back(3'd1);
    send_burst(2, 1, 8'd1, 7'd1, 24'h000001, 1'b1);
    idle(2);
    send_burst(0, 2, 8'd50, 7'd50, 24'h0000AA, 1'b0);
    fork
      send_burst(1, 1, 8'd70, 7'd70, 24'h0000BB, 1'b1);
      begin
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (!busy) break;
          cnt++;
        end
        check(cnt == 4, "timeout_idle_cycles", cnt, 4);
      end
    join
    idle(3);

    // Ignored non-grantee: engine 2 toggles during engine 0's 10-beat burst
    exp_grant_q.push_back(3'd0);
    fork
      send_burst(0, 10, 8'd100, 7'd90, 24'h00C000, 1'b1);
      begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (busy) break;
        end
        for (int k = 0; k < 8; k++) begin
          @(posedge clk);
          #1;
          v_a[2] = k[0];
          l_a[2] = k[1];
          @(negedge clk);
          check(req_ready[2] === 1'b0, "nongrantee_ready", req_ready[2], 0);
        end
        v_a[2] = 1'b0;
        l_a[2] = 1'b0;
      end
    join
    idle(3);

    // Reset mid-burst: engine 1 streaming, then resetn pulse
    mon_en = 1'b0;
    exp_grant_q.push_back(3'd1);
    exp_grant_q.push_back(3'd1);
    v_a[1] = 1'b1; l_a[1] = 1'b0; x_a[1] = 8'd50; y_a[1] = 7'd60; c_a[1] = 24'hABCDEF;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[1]) break;
      cnt++;
    end
    check(cnt < 20, "mid_grant_wait", cnt, 0);
    @(negedge clk);
    check({plot, VGA_X} === {1'b1, 8'd50}, "mid_streaming", {plot, VGA_X}, {1'b1, 8'd50});
    resetn = 1'b0;
    #1;
    check({VGA_X, VGA_Y, VGA_COLOR, plot} === '0, "mid_rst_pixel", {VGA_X, VGA_Y, VGA_COLOR, plot}, 0);
    check({req_ready, busy, grant_id, dbg_rr_ptr} === '0, "mid_rst_ctrl",
          {req_ready, busy, grant_id, dbg_rr_ptr}, 0);
    check(dbg_state === ARB_IDLE, "mid_rst_state", dbg_state, ARB_IDLE);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check({busy, req_ready, grant_id} === {1'b1, 3'b010, 3'd1}, "mid_regrant",
          {busy, req_ready, grant_id}, {1'b1, 3'b010, 3'd1});
    @(posedge clk);
    #1;
    l_a[1] = 1'b1;
    @(posedge clk);
    #1;
    v_a[1] = 1'b0;
    l_a[1] = 1'b0;
    @(negedge clk);
    check({busy, req_ready} === 4'b0000, "mid_last_release", {busy, req_ready}, 0);
    idle(3);

    check(exp_q.size() == 0, "pixels_outstanding", exp_q.size(), 0);
    check(exp_grant_q.size() == 0, "grants_outstanding", exp_grant_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
